// File: rtl/bitwise_gate_pipe.sv
// ----------------------------------------------------------------------------
// bitwise_gate_pipe
//
// Two-stage registered reduction of NCH channel words with a run-time
// selectable operation, a retriggerable "result nonzero" stretcher and a
// saturating hit counter.
//
// Pipeline:
//   stage 1 : masked channel words, mode and enable mask captured on in_valid_i
//   stage 2 : reduction registered into out_data_o, out_valid_o strobes
//   Latency in_valid_i -> out_valid_o is two clock edges, one result per cycle.
//
// A "hit" is a stage-2 result that is valid and nonzero. The hold counter and
// hit_count_o update on the same edge that presents the hit on out_valid_o, so
// cnt_clear_i "coincident with a hit" means sampled on that same edge.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset, clears all state
//   in_data_i    NCH*WIDTH channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid_i   qualifies in_data_i / mode_i / ch_en_i
//   mode_i       00 AND, 01 OR, 10 XOR, 11 pass lowest enabled channel
//   ch_en_i      channel enable mask
//   cnt_clear_i  synchronous clear of hit_count_o (wins over a hit)
//   out_data_o   reduced result, holds while out_valid_o is low
//   out_valid_o  one-cycle strobe per accepted input
//   hit_hold_o   hit flag stretched for HOLD_CYCLES cycles after the last hit
//   hit_count_o  number of hits, saturating at all-ones
// ----------------------------------------------------------------------------
module bitwise_gate_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NCH         = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NCH*WIDTH-1:0] in_data_i,
    input  logic                 in_valid_i,
    input  logic [1:0]           mode_i,
    input  logic [NCH-1:0]       ch_en_i,
    input  logic                 cnt_clear_i,
    output logic [WIDTH-1:0]     out_data_o,
    output logic                 out_valid_o,
    output logic                 hit_hold_o,
    output logic [CNT_WIDTH-1:0] hit_count_o
);

    typedef enum logic [1:0] {
        ModeAnd  = 2'b00,
        ModeOr   = 2'b01,
        ModeXor  = 2'b10,
        ModePass = 2'b11
    } mode_e;

    // HOLD_CYCLES = 0 would give a zero-width counter; keep one bit that simply
    // never leaves zero.
    localparam int unsigned HoldW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES);

    // ------------------------------------------------------------------------
    // Stage 1: capture masked words
    // ------------------------------------------------------------------------
    logic [NCH*WIDTH-1:0] in_masked;
    logic [NCH*WIDTH-1:0] data1_q;
    mode_e                mode1_q;
    logic [NCH-1:0]       en1_q;
    logic                 v1_q;

    // Disabled channels are zeroed here; stage 2 substitutes the AND identity.
    always_comb begin
        in_masked = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_en_i[k]) begin
                in_masked[k*WIDTH +: WIDTH] = in_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data1_q <= '0;
            mode1_q <= ModeAnd;
            en1_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                data1_q <= in_masked;
                mode1_q <= mode_e'(mode_i);
                en1_q   <= ch_en_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: reduction
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] red_and;
    logic [WIDTH-1:0] red_or;
    logic [WIDTH-1:0] red_xor;
    logic [WIDTH-1:0] red_pass;
    logic             pass_found;
    logic [WIDTH-1:0] result_d;
    logic             any_en;

    always_comb begin
        red_and    = '1;
        red_or     = '0;
        red_xor    = '0;
        red_pass   = '0;
        pass_found = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (en1_q[k]) begin
                red_and = red_and & data1_q[k*WIDTH +: WIDTH];
            end
            // Disabled words are already zero, the OR/XOR identity.
            red_or  = red_or  | data1_q[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ data1_q[k*WIDTH +: WIDTH];
            if (en1_q[k] && !pass_found) begin
                red_pass   = data1_q[k*WIDTH +: WIDTH];
                pass_found = 1'b1;
            end
        end
    end

    assign any_en = |en1_q;

    always_comb begin
        result_d = '0;
        unique case (mode1_q)
            ModeAnd:  result_d = red_and;
            ModeOr:   result_d = red_or;
            ModeXor:  result_d = red_xor;
            ModePass: result_d = red_pass;
        endcase
        // An all-ones AND identity must not leak out when nothing is enabled.
        if (!any_en) begin
            result_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Hit detection, stretcher and counter
    // ------------------------------------------------------------------------
    logic                 hit_d;
    logic [WIDTH-1:0]     out_data_q;
    logic                 out_valid_q;
    logic [HoldW-1:0]     hold_cnt_q;
    logic [HoldW-1:0]     hold_cnt_d;
    logic                 hit_hold_q;
    logic                 hit_hold_d;
    logic [CNT_WIDTH-1:0] hit_count_q;
    logic [CNT_WIDTH-1:0] hit_count_d;

    assign hit_d = v1_q && (result_d != '0);

    // hit_hold uses the pre-reload counter value, so a single hit stays high for
    // the strobe cycle plus HOLD_CYCLES more; with HOLD_CYCLES = 0 the counter
    // never leaves zero and hit_hold tracks the hit strobe exactly.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (hit_d) begin
            hold_cnt_d = HoldLoad;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HoldW'(1);
        end
        hit_hold_d = hit_d || (hold_cnt_q != '0);
    end

    always_comb begin
        hit_count_d = hit_count_q;
        if (cnt_clear_i) begin
            hit_count_d = '0;
        end else if (hit_d && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            hit_hold_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_data_q <= result_d;
            end
            hold_cnt_q  <= hold_cnt_d;
            hit_hold_q  <= hit_hold_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign hit_hold_o  = hit_hold_q;
    assign hit_count_o = hit_count_q;

endmodule

// File: doc/bitwise_gate_pipe.md
Name: bitwise_gate_pipe

Overview:
Parametrised, registered successor to the team's single-pair bitwise gate. It reduces NCH input words of WIDTH bits with a run-time selectable operation (AND / OR / XOR / pass-through) under a channel-enable mask. It is pipelined with a valid flag and adds a retriggerable hit-hold stretcher plus a saturating hit counter. It sits between the HPF test stimulus and DAC debug outputs, gating and flagging channel activity.

Parameters:
WIDTH, 8, bits per channel word
NCH, 4, number of input channels (>=2)
HOLD_CYCLES, 16, cycles hit_hold stays high after last hit (0 = no stretch)
CNT_WIDTH, 16, width of saturating hit counter

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high; clears all state
in_data  input  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
in_valid  input  1  in_data/mode/ch_en sampled when high
mode  input  2  00 AND, 01 OR, 10 XOR, 11 pass lowest enabled channel
ch_en  input  NCH  channel enable mask
cnt_clear  input  1  synchronous clear of hit_count
out_data  output  WIDTH  reduced result
out_valid  output  1  one-cycle strobe, out_data valid
hit_hold  output  1  stretched "result nonzero" flag
hit_count  output  CNT_WIDTH  number of valid nonzero results, saturating

Behaviour:
- Reset: out_data=0, out_valid=0, hit_hold=0, hit_count=0, hold counter=0, all pipeline regs and valids=0. Asynchronous assertion; release takes effect on next clk edge.
- Stage 1 (edge after in_valid=1): latch masked inputs, mode, ch_en, v1=1. When in_valid=0, v1=0 and data regs hold their value.
- Stage 2 (next edge): compute reduction into out_data; out_valid=v1. Latency in_valid to out_valid = 2 cycles. Full throughput: one result per cycle with back-to-back in_valid.
- Disabled channels contribute the identity: all-ones for AND, zero for OR/XOR.
- ch_en=0 (all disabled): out_data=0 for every mode.
- mode 11: out_data = lowest-index enabled channel word.
- out_data holds its last value while out_valid=0.
- Hit = out_valid & (out_data != 0), evaluated on the stage-2 result.
- Hold counter, width clog2(HOLD_CYCLES+1):
  - Hit reloads it to HOLD_CYCLES and sets hit_hold=1 the same cycle out_valid rises.
  - Otherwise, if nonzero, it decrements; hit_hold = (counter != 0) | hit.
  - A retrigger while counting reloads to the full value (no accumulation).
  - HOLD_CYCLES=0: hit_hold equals the hit strobe exactly.
- hit_count increments by 1 on each hit and saturates at 2^CNT_WIDTH-1 (no wrap). cnt_clear sets it to 0 on the next edge. Simultaneous cnt_clear and hit: clear wins, result 0.
- Reset mid-stream: in-flight pipeline data is discarded and no out_valid is emitted for inputs accepted before reset.
- mode/ch_en changes apply per sample; no glitch on outputs, since all outputs are registered.

Test Plan:
- Reset check: assert reset mid-run with a pipeline full and hold counting -> all outputs 0 immediately; first out_valid appears exactly 2 cycles after the first post-reset in_valid.
- Mode sweep (WIDTH=8, NCH=4, ch_en=4'b1111, words ch0..ch3 = F0,3C,FF,0F): AND -> 00 (no hit, hit_count unchanged); OR -> FF; XOR -> 3C; pass -> F0. out_valid arrives 2 cycles after each in_valid; back-to-back inputs give 4 consecutive strobes.
- Mask: ch_en=4'b0110, AND of 3C,FF -> 3C; ch_en=0 with any mode -> 00; mode 11 with ch_en=4'b1000 -> ch3 word 0F.
- Hold stretcher (HOLD_CYCLES=16): one hit -> hit_hold high for 17 cycles total then low. A second hit 10 cycles after the first extends to 16 cycles past the second hit. Rebuild with HOLD_CYCLES=0 -> hit_hold is a 1-cycle pulse.
- Counter (CNT_WIDTH=4): 20 consecutive hits -> hit_count stops at 15. cnt_clear coincident with a hit -> 0. The next hit -> 1.
